// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: state codes,
// opcode/funct values, ALU operations, instruction classes and mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC     = 4'd3,
        S_WB       = 4'd4,
        S_BRANCH   = 4'd5,
        S_JAL_LINK = 4'd6,
        S_JUMP     = 4'd7,
        S_MEM_ADDR = 4'd8,
        S_MEM_RD   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_MEM_WB   = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_RTYPE   = 4'd1,
        CLS_ITYPE   = 4'd2,
        CLS_JR      = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JUMP    = 4'd5,
        CLS_JAL     = 4'd6,
        CLS_LOAD    = 4'd7,
        CLS_STORE   = 4'd8
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_MUL   = 6'h1c;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_MUL  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    localparam logic [1:0] ALUB_RT     = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_S2 = 2'b11;

    localparam logic [1:0] EXT_SIGN  = 2'b00;
    localparam logic [1:0] EXT_ZERO  = 2'b01;
    localparam logic [1:0] EXT_LUI   = 2'b10;
    localparam logic [1:0] EXT_SIGNU = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational instruction classifier: latched op/funct to class, ALU
// operation and the datapath mux settings used during EXEC/WB.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls,
    output logic [2:0] alu_op,
    output logic [1:0] ext_mode,
    output logic [1:0] reg_dst,
    output logic [1:0] alu_b,
    output logic       legal
);

    always_comb begin
        cls      = CLS_ILLEGAL;
        alu_op   = ALU_ADD;
        ext_mode = EXT_SIGN;
        reg_dst  = RDST_RT;
        alu_b    = ALUB_IMM;
        case (op)
            OP_RTYPE: begin
                cls     = CLS_RTYPE;
                alu_b   = ALUB_RT;
                reg_dst = RDST_RD;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_JR: begin
                        cls    = CLS_JR;
                        alu_op = ALU_PASS;
                    end
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            // mul shares the register-register format, funct is not examined
            OP_MUL: begin
                cls     = CLS_RTYPE;
                alu_b   = ALUB_RT;
                reg_dst = RDST_RD;
                alu_op  = ALU_MUL;
            end
            OP_ADDI:  cls = CLS_ITYPE;
            OP_ADDIU: begin
                cls      = CLS_ITYPE;
                ext_mode = EXT_SIGNU;
            end
            OP_SLTI: begin
                cls    = CLS_ITYPE;
                alu_op = ALU_SLT;
            end
            OP_ANDI: begin
                cls      = CLS_ITYPE;
                alu_op   = ALU_AND;
                ext_mode = EXT_ZERO;
            end
            OP_ORI: begin
                cls      = CLS_ITYPE;
                alu_op   = ALU_OR;
                ext_mode = EXT_ZERO;
            end
            // lui relies on rs = $0 so rs + (imm<<16) is the result
            OP_LUI: begin
                cls      = CLS_ITYPE;
                ext_mode = EXT_LUI;
            end
            OP_BEQ, OP_BNE: begin
                cls    = CLS_BRANCH;
                alu_op = ALU_SUB;
                alu_b  = ALUB_RT;
            end
            OP_J:    cls = CLS_JUMP;
            OP_JAL:  cls = CLS_JAL;
            OP_LW:   cls = CLS_LOAD;
            OP_SW:   cls = CLS_STORE;
            default: cls = CLS_ILLEGAL;
        endcase
        legal = (cls != CLS_ILLEGAL);
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch through
// writeback, with memory wait states, illegal-opcode trap and retire counter.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_WAIT_EN = 1,
    parameter int TRAP_EN     = 1,
    parameter int RETIRE_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    input  logic                  trap_clear,
    output logic                  pc_w,
    output logic                  ir_w,
    output logic                  reg_w,
    output logic                  mem_w,
    output logic                  mem_req,
    output logic                  ins_dat,
    output logic                  pc_src,
    output logic                  pc_jump,
    output logic                  branch,
    output logic                  branch_ne,
    output logic                  alu_a,
    output logic [1:0]            alu_b,
    output logic [1:0]            ext_mode,
    output logic [1:0]            reg_dst,
    output logic                  mem_reg,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  trap,
    output logic                  instr_done,
    output logic [3:0]            state,
    output logic [RETIRE_W-1:0]   retire_count
);

    state_t              state_q, state_d;
    logic [5:0]          op_q, funct_q;
    logic [RETIRE_W-1:0] retire_q;
    logic [2:0]          alu_op;
    logic                mem_rdy;

    cls_t       dec_cls;
    logic [2:0] dec_alu;
    logic [1:0] dec_ext, dec_rdst, dec_alub;
    logic       dec_legal;

    assign mem_rdy      = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
    assign retire_count = retire_q;

    mc_op_decode u_dec (
        .op       (op_q),
        .funct    (funct_q),
        .cls      (dec_cls),
        .alu_op   (dec_alu),
        .ext_mode (dec_ext),
        .reg_dst  (dec_rdst),
        .alu_b    (dec_alub),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RESET;
            op_q     <= '0;
            funct_q  <= '0;
            retire_q <= '0;
        end else begin
            state_q <= state_d;
            // IR fields are captured only when the fetch actually completes
            if (state_q == S_FETCH && mem_rdy) begin
                op_q    <= op;
                funct_q <= funct;
            end
            if (instr_done)
                retire_q <= retire_q + RETIRE_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        mem_req    = 1'b0;
        ins_dat    = 1'b0;
        pc_src     = 1'b0;
        pc_jump    = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        alu_a      = 1'b0;
        alu_b      = ALUB_RT;
        ext_mode   = EXT_SIGN;
        reg_dst    = RDST_RT;
        mem_reg    = 1'b0;
        alu_op     = 3'b000;
        trap       = 1'b0;
        instr_done = 1'b0;
        state      = state_q;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                ir_w    = mem_rdy;
                pc_w    = mem_rdy;
                alu_b   = ALUB_FOUR;
                alu_op  = ALU_ADD;
                pc_jump = 1'b1;
                if (mem_rdy)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                // branch target is precomputed here while the class resolves
                alu_b  = ALUB_IMM_S2;
                alu_op = ALU_ADD;
                if (!dec_legal) begin
                    if (TRAP_EN != 0) begin
                        state_d = S_TRAP;
                    end else begin
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
                    end
                end else begin
                    case (dec_cls)
                        CLS_BRANCH:          state_d = S_BRANCH;
                        CLS_JUMP:            state_d = S_JUMP;
                        CLS_JAL:             state_d = S_JAL_LINK;
                        CLS_LOAD, CLS_STORE: state_d = S_MEM_ADDR;
                        default:             state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC, S_WB: begin
                alu_a    = 1'b1;
                alu_b    = dec_alub;
                ext_mode = dec_ext;
                reg_dst  = dec_rdst;
                alu_op   = dec_alu;
                if (state_q == S_WB) begin
                    reg_w      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (dec_cls == CLS_JR) begin
                    pc_w       = 1'b1;
                    pc_src     = 1'b1;
                    pc_jump    = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_BRANCH: begin
                alu_a      = 1'b1;
                alu_b      = ALUB_RT;
                alu_op     = ALU_SUB;
                branch     = 1'b1;
                branch_ne  = (op_q == OP_BNE);
                pc_src     = 1'b1;
                pc_jump    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL_LINK: begin
                // PC already holds the return address after the fetch increment
                reg_w   = 1'b1;
                reg_dst = RDST_RA;
                alu_op  = ALU_PASS;
                state_d = S_JUMP;
            end
            S_JUMP: begin
                pc_w       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_a   = 1'b1;
                alu_b   = ALUB_IMM;
                alu_op  = ALU_ADD;
                state_d = (dec_cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ins_dat = 1'b1;
                mem_req = 1'b1;
                if (mem_rdy)
                    state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                ins_dat = 1'b1;
                mem_req = 1'b1;
                mem_w   = 1'b1;
                if (mem_rdy) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM_WB: begin
                reg_w      = 1'b1;
                mem_reg    = 1'b1;
                reg_dst    = RDST_RT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
                if (trap_clear)
                    state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // reset forces a quiet control bus even before the register clears
        if (rst) begin
            pc_w       = 1'b0;
            ir_w       = 1'b0;
            reg_w      = 1'b0;
            mem_w      = 1'b0;
            mem_req    = 1'b0;
            ins_dat    = 1'b0;
            pc_src     = 1'b0;
            pc_jump    = 1'b0;
            branch     = 1'b0;
            branch_ne  = 1'b0;
            alu_a      = 1'b0;
            alu_b      = 2'b00;
            ext_mode   = 2'b00;
            reg_dst    = 2'b00;
            mem_reg    = 1'b0;
            alu_op     = 3'b000;
            trap       = 1'b0;
            instr_done = 1'b0;
            state      = 4'd0;
        end
        alu_ctrl = ALU_CTRL_W'(alu_op);
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed instruction table, hand sequences for
// wait states / trap / reset, and randomized instruction streams.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst, mem_ready, trap_clear;
    logic [5:0] op, funct;

    logic pc_w, ir_w, reg_w, mem_w, mem_req, ins_dat, pc_src, pc_jump;
    logic branch, branch_ne, alu_a, mem_reg, trap, instr_done;
    logic [1:0] alu_b, ext_mode, reg_dst;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
    logic [31:0] retire_count;

    logic pc_w_n, ir_w_n, reg_w_n, mem_w_n, mem_req_n, ins_dat_n, pc_src_n, pc_jump_n;
    logic branch_n, branch_ne_n, alu_a_n, mem_reg_n, trap_n, instr_done_n;
    logic [1:0] alu_b_n, ext_mode_n, reg_dst_n;
    logic [2:0] alu_ctrl_n;
    logic [3:0] state_n;
    logic [1:0] retire_n;

    logic [26:0] outs;
    assign outs = {pc_w, ir_w, reg_w, mem_w, mem_req, ins_dat, pc_src, pc_jump, branch,
                   branch_ne, alu_a, alu_b, ext_mode, reg_dst, mem_reg, alu_ctrl, trap,
                   instr_done, state};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
        .trap_clear(trap_clear), .pc_w(pc_w), .ir_w(ir_w), .reg_w(reg_w), .mem_w(mem_w),
        .mem_req(mem_req), .ins_dat(ins_dat), .pc_src(pc_src), .pc_jump(pc_jump),
        .branch(branch), .branch_ne(branch_ne), .alu_a(alu_a), .alu_b(alu_b),
        .ext_mode(ext_mode), .reg_dst(reg_dst), .mem_reg(mem_reg), .alu_ctrl(alu_ctrl),
        .trap(trap), .instr_done(instr_done), .state(state), .retire_count(retire_count)
    );

    // second instance: unknown opcodes retire as NOPs, narrow counter to see wrap
    mc_control_fsm #(.TRAP_EN(0), .RETIRE_W(2)) dut_nt (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready),
        .trap_clear(trap_clear), .pc_w(pc_w_n), .ir_w(ir_w_n), .reg_w(reg_w_n),
        .mem_w(mem_w_n), .mem_req(mem_req_n), .ins_dat(ins_dat_n), .pc_src(pc_src_n),
        .pc_jump(pc_jump_n), .branch(branch_n), .branch_ne(branch_ne_n), .alu_a(alu_a_n),
        .alu_b(alu_b_n), .ext_mode(ext_mode_n), .reg_dst(reg_dst_n), .mem_reg(mem_reg_n),
        .alu_ctrl(alu_ctrl_n), .trap(trap_n), .instr_done(instr_done_n), .state(state_n),
        .retire_count(retire_n)
    );

    // per-cycle snapshots of the most recent instruction
    logic [3:0] s_state [0:47];
    logic       s_regw [0:47], s_done [0:47], s_memreq [0:47], s_memreg [0:47];
    logic       s_branch [0:47], s_bne [0:47], s_pcw [0:47], s_pcjump [0:47];
    logic [1:0] s_regdst [0:47];
    logic [2:0] s_alu [0:47];

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         fw;
        int         mw;
        int         cycles;
        logic [3:0] st2;
    } vec_t;

    vec_t tbl [12];
    logic [11:0] legal_ops [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        trap_clear = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk("reset_outs", 32'(outs), 32'd0);
        chk("reset_retire", retire_count, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_reset_fetch", 32'(state), 32'(S_FETCH));
    endtask

    // Runs one instruction from FETCH: fetch stalls fw cycles, memory stage
    // stalls mw cycles; op/funct are garbage after the fetch completes.
    task automatic exec_instr(input logic [5:0] iop, input logic [5:0] ifn,
                              input int fw, input int mw, output int cyc);
        bit ended = 0;
        cyc = 0;
        for (int k = 0; k < 40 && !ended; k++) begin
            if (k <= fw) begin
                op = iop;
                funct = ifn;
                mem_ready = (k == fw);
            end else begin
                op = 6'($urandom);
                funct = 6'($urandom);
                if (k >= fw + 3 && k < fw + 3 + mw) mem_ready = 1'b0;
                else if (k >= fw + 3)                mem_ready = 1'b1;
                else                                 mem_ready = 1'($urandom);
            end
            #1;
            s_state[k] = state;   s_regw[k] = reg_w;     s_done[k] = instr_done;
            s_memreq[k] = mem_req; s_memreg[k] = mem_reg; s_branch[k] = branch;
            s_bne[k] = branch_ne; s_pcw[k] = pc_w;       s_pcjump[k] = pc_jump;
            s_regdst[k] = reg_dst; s_alu[k] = alu_ctrl;
            if (instr_done === 1'b1 || trap === 1'b1) begin
                ended = 1;
                cyc = k + 1;
            end
            @(posedge clk);
            #1;
        end
        chk("instr_timeout", 32'(ended), 32'd1);
    endtask

    // reference timing from the instruction-class rules
    function automatic int ref_len(input logic [5:0] o, input logic [5:0] f,
                                   input int fw, input int mw);
        int base;
        if (o == 6'h00 && f == 6'h08)      base = 3;
        else if (o == 6'h04 || o == 6'h05) base = 3;
        else if (o == 6'h02)               base = 3;
        else if (o == 6'h03)               base = 4;
        else if (o == 6'h23)               base = 5 + mw;
        else if (o == 6'h2b)               base = 4 + mw;
        else                               base = 4;
        return base + fw;
    endfunction

    function automatic logic [3:0] ref_st2(input logic [5:0] o);
        case (o)
            6'h04, 6'h05: return S_BRANCH;
            6'h02:        return S_JUMP;
            6'h03:        return S_JAL_LINK;
            6'h23, 6'h2b: return S_MEM_ADDR;
            default:      return S_EXEC;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, r0, fw, mw, idx;
        logic [31:0] exp_ret;

        tbl[0]  = '{6'h00, 6'h20, 0, 0, 4, S_EXEC};
        tbl[1]  = '{6'h23, 6'h00, 0, 3, 8, S_MEM_ADDR};
        tbl[2]  = '{6'h05, 6'h00, 0, 0, 3, S_BRANCH};
        tbl[3]  = '{6'h04, 6'h00, 0, 0, 3, S_BRANCH};
        tbl[4]  = '{6'h03, 6'h00, 0, 0, 4, S_JAL_LINK};
        tbl[5]  = '{6'h02, 6'h00, 1, 0, 4, S_JUMP};
        tbl[6]  = '{6'h2b, 6'h00, 0, 2, 6, S_MEM_ADDR};
        tbl[7]  = '{6'h00, 6'h08, 0, 0, 3, S_EXEC};
        tbl[8]  = '{6'h08, 6'h00, 2, 0, 6, S_EXEC};
        tbl[9]  = '{6'h0f, 6'h00, 0, 0, 4, S_EXEC};
        tbl[10] = '{6'h1c, 6'h02, 0, 0, 4, S_EXEC};
        tbl[11] = '{6'h00, 6'h22, 0, 0, 4, S_EXEC};

        legal_ops = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25},
                      {6'h00, 6'h2a}, {6'h00, 6'h08}, {6'h08, 6'h00}, {6'h09, 6'h00},
                      {6'h0a, 6'h00}, {6'h0c, 6'h00}, {6'h0d, 6'h00}, {6'h0f, 6'h00},
                      {6'h1c, 6'h02}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00},
                      {6'h03, 6'h00}, {6'h23, 6'h00}, {6'h2b, 6'h00}};

        op = '0; funct = '0;
        do_reset();

        for (int i = 0; i < 12; i++) begin
            r0 = int'(retire_count);
            exec_instr(tbl[i].op, tbl[i].fn, tbl[i].fw, tbl[i].mw, cyc);
            chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cycles);
            chk($sformatf("tbl%0d_st2", i), 32'(s_state[tbl[i].fw + 2]), 32'(tbl[i].st2));
            chk($sformatf("tbl%0d_retire", i), retire_count, 32'(r0 + 1));
            case (i)
                0: begin
                    for (int k = 0; k < 4; k++)
                        chk($sformatf("add_regw_c%0d", k), 32'(s_regw[k]), 32'(k == 3));
                    chk("add_exec_state", 32'(s_state[2]), 32'(S_EXEC));
                    chk("add_wb_state", 32'(s_state[3]), 32'(S_WB));
                    chk("add_wb_regdst", 32'(s_regdst[3]), 32'h1);
                    chk("add_first_retire", retire_count, 32'd1);
                end
                1: begin
                    for (int k = 3; k < 6; k++) begin
                        chk($sformatf("lw_hold_state_c%0d", k), 32'(s_state[k]), 32'(S_MEM_RD));
                        chk($sformatf("lw_hold_req_c%0d", k), 32'(s_memreq[k]), 32'd1);
                    end
                    chk("lw_memwb_state", 32'(s_state[7]), 32'(S_MEM_WB));
                    chk("lw_memwb_memreg", 32'(s_memreg[7]), 32'd1);
                    chk("lw_memwb_regdst", 32'(s_regdst[7]), 32'h0);
                end
                2, 3: begin
                    chk($sformatf("br%0d_branch", i), 32'(s_branch[2]), 32'd1);
                    chk($sformatf("br%0d_ne", i), 32'(s_bne[2]), 32'(i == 2));
                    chk($sformatf("br%0d_alu", i), 32'(s_alu[2]), 32'h4);
                end
                4: begin
                    chk("jal_link_regdst", 32'(s_regdst[2]), 32'h2);
                    chk("jal_link_regw", 32'(s_regw[2]), 32'd1);
                    chk("jal_link_done", 32'(s_done[2]), 32'd0);
                    chk("jal_jump_state", 32'(s_state[3]), 32'(S_JUMP));
                    chk("jal_jump_pcw", 32'(s_pcw[3]), 32'd1);
                    chk("jal_jump_pcjump", 32'(s_pcjump[3]), 32'd0);
                end
                default: ;
            endcase
        end

        // randomized instruction stream against the timing reference
        exp_ret = retire_count;
        for (int n = 0; n < 60; n++) begin
            idx = $urandom_range(0, 18);
            fw = $urandom_range(0, 3);
            mw = (legal_ops[idx][11:6] == 6'h23 || legal_ops[idx][11:6] == 6'h2b)
                 ? $urandom_range(0, 3) : 0;
            exec_instr(legal_ops[idx][11:6], legal_ops[idx][5:0], fw, mw, cyc);
            exp_ret = exp_ret + 32'd1;
            chk($sformatf("rnd%0d_op%0h_cycles", n, legal_ops[idx][11:6]), cyc,
                ref_len(legal_ops[idx][11:6], legal_ops[idx][5:0], fw, mw));
            chk($sformatf("rnd%0d_st2", n), 32'(s_state[fw + 2]),
                32'(ref_st2(legal_ops[idx][11:6])));
            chk($sformatf("rnd%0d_retire", n), retire_count, exp_ret);
        end

        // reset arriving while a store is stalled on memory
        op = 6'h2b; funct = '0; mem_ready = 1'b1;
        tick();
        op = 6'h00;
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("sw_stall_state", 32'(state), 32'(S_MEM_WR));
        chk("sw_stall_memw", 32'(mem_w), 32'd1);
        tick();
        chk("sw_stall_hold", 32'(state), 32'(S_MEM_WR));
        rst = 1'b1;
        tick();
        chk("midwr_reset_outs", 32'(outs), 32'd0);
        chk("midwr_reset_retire", retire_count, 32'd0);
        rst = 1'b0;
        tick();
        chk("midwr_release_fetch", 32'(state), 32'(S_FETCH));

        // illegal opcode: trap vs NOP, and op changing under DECODE
        do_reset();
        op = 6'h3f; funct = '0; mem_ready = 1'b1; trap_clear = 1'b0;
        tick();
        op = 6'h00; funct = 6'h20;
        #1;
        chk("ill_decode_state", 32'(state), 32'(S_DECODE));
        chk("ill_decode_done", 32'(instr_done), 32'd0);
        chk("nt_decode_done", 32'(instr_done_n), 32'd1);
        tick();
        chk("trap_state", 32'(state), 32'(S_TRAP));
        chk("trap_flag", 32'(trap), 32'd1);
        chk("trap_retire", retire_count, 32'd0);
        chk("nt_fetch_state", 32'(state_n), 32'(S_FETCH));
        chk("nt_retire", 32'(retire_n), 32'd1);
        tick();
        tick();
        chk("trap_hold", 32'(state), 32'(S_TRAP));
        chk("trap_hold_done", 32'(instr_done), 32'd0);
        trap_clear = 1'b1;
        tick();
        trap_clear = 1'b0;
        chk("trap_clear_fetch", 32'(state), 32'(S_FETCH));
        chk("trap_clear_flag", 32'(trap), 32'd0);

        // NOP retirements wrap the narrow counter
        do_reset();
        op = 6'h3f; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            chk($sformatf("nt_wrap%0d", i), 32'(retire_n), 32'((i + 1) % 4));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multicycle MIPS-subset control unit, successor to the fixed single-width controller. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and drives datapath select/enable strobes. New over the previous generation: latched opcode/funct, memory wait-state handshake, BNE, full R-type ALU set, illegal-opcode trap, and a retired-instruction counter. Sits beside the datapath; consumes IR fields, branch-compare and memory-ready, and emits control.

Parameters:
ALU_CTRL_W, 3, width of alu_ctrl; encodings are zero-extended package constants.
MEM_WAIT_EN, 1, 1 = FETCH/MEM states hold until mem_ready; 0 = mem_ready ignored (treated as 1).
TRAP_EN, 1, 1 = unknown op/funct enters TRAP; 0 = unknown treated as NOP (DECODE->FETCH).
RETIRE_W, 32, width of retire_count.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
mem_ready  in  1  memory completes the current access this cycle
trap_clear  in  1  leave TRAP
pc_w, ir_w, reg_w, mem_w, mem_req  out  1  each  PC/IR/regfile/memory write enables; memory request
ins_dat  out  1  0 = memory address from PC, 1 = from ALUOut
pc_src  out  1  0 = ALU result, 1 = ALUOut/jump target
pc_jump  out  1  0 = jump-address mux, 1 = pc_src path
branch, branch_ne  out  1  each  conditional PC write; branch_ne inverts the zero test
alu_a  out  1  0 = PC, 1 = rs
alu_b  out  2  00 rt, 01 const 4, 10 extended imm, 11 imm<<2
ext_mode  out  2  00 sign, 01 zero, 10 lui (imm<<16), 11 sign (unsigned add)
reg_dst  out  2  00 rt, 01 rd, 10 $31
mem_reg  out  1  writeback from memory data
alu_ctrl  out  ALU_CTRL_W  ALU operation
trap  out  1  high while in TRAP
instr_done  out  1  one-cycle pulse on last cycle of each instruction
state  out  4  current state code, debug
retire_count  out  RETIRE_W  instructions completed

Behaviour:
- Moore outputs decoded from state register plus op_q/funct_q; op_q/funct_q captured from op/funct on the FETCH cycle that completes (ir_w high and mem_ready).
- While rst=1: every output 0, retire_count 0, op_q/funct_q 0; next cycle state=FETCH.
- FETCH: mem_req=1, ir_w=pc_w=mem_ready-qualified, alu_a=0, alu_b=01, alu_ctrl=ADD, pc_jump=1. Stays in FETCH until mem_ready (MEM_WAIT_EN=1); -> DECODE.
- DECODE: alu_a=0, alu_b=11, ADD (branch target precompute). Next: beq/bne->BRANCH; j->JUMP; jal->JAL_LINK; lw/sw->MEM_ADDR; known R-type/I-type->EXEC; else TRAP (TRAP_EN) or FETCH with instr_done.
- EXEC: ALU setup per op (R: alu_a=1, alu_b=00, reg_dst=01; I: alu_b=10, ext_mode per op). jr: pc_w=1, pc_src=1, alu_ctrl=PASS, -> FETCH with instr_done. Others -> WB.
- WB: reg_w=1, same mux settings as EXEC, instr_done=1 -> FETCH.
- BRANCH: alu_a=1, alu_b=00, SUB, branch=1, branch_ne=(op_q==05), pc_src=1; -> FETCH, instr_done.
- JAL_LINK: reg_w=1, reg_dst=10, alu_a=0, alu_b=00, alu_ctrl=PASS (PC already +4) -> JUMP.
- JUMP: pc_w=1, pc_jump=0; -> FETCH, instr_done.
- MEM_ADDR: alu_a=1, alu_b=10, ADD -> MEM_RD (lw) / MEM_WR (sw).
- MEM_RD/MEM_WR: ins_dat=1, mem_req=1, mem_w=1 in MEM_WR; hold until mem_ready. MEM_WR -> FETCH with instr_done; MEM_RD -> MEM_WB (reg_w=1, mem_reg=1, reg_dst=00, instr_done) -> FETCH.
- TRAP: trap=1, all enables 0; trap_clear -> FETCH. No instr_done.
- retire_count += 1 on every instr_done; wraps modulo 2^RETIRE_W.
- mem_ready outside FETCH/MEM_RD/MEM_WR ignored. Illegal state code -> FETCH.
- Supported: R add 20, sub 22, and 24, or 25, slt 2a, jr 08; addi 08, addiu 09, slti 0a, andi 0c, ori 0d, lui 0f, mul 1c, beq 04, bne 05, j 02, jal 03, lw 23, sw 2b.

Decomposition:
- Package mc_ctrl_pkg: state codes, opcode/funct constants, ALU_ADD=001, AND=010, OR=011, SUB=100, SLT=101, MUL=110, PASS=111, alu_b/ext_mode/reg_dst select constants.
- One sub-module mc_op_decode (combinational: op_q/funct_q -> class, alu_ctrl, ext_mode, reg_dst, legal flag); FSM and counter stay in top.

Test Plan:
- add (op 00, funct 20), mem_ready=1 always -> FETCH,DECODE,EXEC,WB; reg_w=1 and reg_dst=01 only in WB; retire_count 0->1 after 4 cycles.
- lw (op 23), mem_ready low 3 cycles in MEM_RD -> state holds in MEM_RD 3 cycles, mem_req stays 1, then MEM_WB with mem_reg=1; total 8 cycles.
- bne (op 05) -> BRANCH with branch=1, branch_ne=1, alu_ctrl=100; beq (04) gives branch_ne=0; both 3 cycles.
- jal (op 03) -> JAL_LINK reg_dst=10, reg_w=1, then JUMP pc_w=1, pc_jump=0; instr_done only in JUMP.
- op 3f, TRAP_EN=1 -> TRAP, trap=1, retire_count unchanged; trap_clear=1 -> FETCH. TRAP_EN=0 -> FETCH after DECODE, count +1.
- rst=1 asserted mid MEM_WR -> next cycle all outputs 0, retire_count 0; after release state=FETCH; op change during DECODE does not alter decode (op_q latched).
